// File: rtl/prbs_pkg.sv
// Shared PRBS checker types and helpers: FSM state enum, default PRBS7
// polynomial constants and the popcount used for bit-error accounting.
package prbs_pkg;

  typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  localparam int         PRBS7_W    = 7;
  localparam logic [7:0] PRBS7_MASK = 8'hC0;

  // Callers zero-extend their word to 256 bits.
  function automatic logic [31:0] popcount(input logic [255:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 256; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/prbs_par_gen.sv
// Combinational parallel PN predictor: full = {seed, pn}, high indices older,
// pn[i] = ^(full[i +: POL_W+1] & POL_MASK).
module prbs_par_gen #(
  parameter int               POL_W    = 7,
  parameter logic [POL_W:0]   POL_MASK = 8'hC0,
  parameter int               DW       = 16
) (
  input  logic [POL_W-1:0] seed,
  output logic [DW-1:0]    pn
);

  always_comb begin
    logic [POL_W+DW-1:0] full;
    full = {seed, {DW{1'b0}}};
    // Oldest output bit first so every tap it reads is already resolved.
    for (int i = DW - 1; i >= 0; i--)
      full[i] = ^(full[i +: POL_W+1] & POL_MASK);
    pn = full[DW-1:0];
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising parallel PRBS checker with lock/loss FSM and saturating
// error counters. Define PRBS_CHK_BITCNT_EN to build the bit-error popcount path.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int             POL_W    = PRBS7_W,
  parameter logic [POL_W:0] POL_MASK = PRBS7_MASK,
  parameter int             DW       = 16,
  parameter int             LOCK_CNT = 8,
  parameter int             LOSS_CNT = 4,
  parameter int             CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            data_in,
  input  logic                     data_valid,
  input  logic                     clear_cnt,
  output logic                     locked,
  output logic                     err_word,
  output logic [$clog2(DW+1)-1:0]  err_bits,
  output logic [CNT_W-1:0]         err_word_cnt,
  output logic [CNT_W-1:0]         err_bit_cnt
);

  localparam int EBW = $clog2(DW+1);
  localparam int MW  = $clog2(LOCK_CNT+1);
  localparam int LW  = $clog2(LOSS_CNT+1);

  state_e           state;
  logic [POL_W-1:0] seed_q;
  logic             has_prev;
  logic [MW-1:0]    match_cnt;
  logic [LW-1:0]    miss_cnt;
  logic [DW-1:0]    exp_w;
  logic [DW-1:0]    mism;
  logic             err_evt;

  prbs_par_gen #(.POL_W(POL_W), .POL_MASK(POL_MASK), .DW(DW)) u_gen (
    .seed (seed_q),
    .pn   (exp_w)
  );

  assign mism    = data_in ^ exp_w;
  assign err_evt = data_valid && (state == LOCKED) && (|mism);
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEARCH;
      seed_q       <= '0;
      has_prev     <= 1'b0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      err_word     <= 1'b0;
      err_word_cnt <= '0;
    end else begin
      err_word <= err_evt;
      if (data_valid) begin
        if (state == SEARCH) begin
          seed_q   <= data_in[POL_W-1:0];
          has_prev <= 1'b1;
          if (has_prev && data_in == exp_w) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            match_cnt <= '0;
          end
        end else begin
          // Free-run from the prediction so a corrupted word cannot poison the seed.
          seed_q <= exp_w[POL_W-1:0];
          if (err_evt) begin
            if (miss_cnt == LW'(LOSS_CNT - 1)) begin
              state     <= SEARCH;
              match_cnt <= '0;
              miss_cnt  <= '0;
              has_prev  <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end else begin
            miss_cnt <= '0;
          end
        end
      end
      if (clear_cnt)
        err_word_cnt <= '0;
      else if (err_evt && !(&err_word_cnt))
        err_word_cnt <= err_word_cnt + 1'b1;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  localparam int SW = ((CNT_W > EBW) ? CNT_W : EBW) + 1;

  logic [EBW-1:0] pop;
  logic [SW-1:0]  bit_sum;

  assign pop     = EBW'(popcount(256'(mism)));
  assign bit_sum = SW'(err_bit_cnt) + SW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_bits    <= '0;
      err_bit_cnt <= '0;
    end else begin
      err_bits <= err_evt ? pop : '0;
      if (clear_cnt)
        err_bit_cnt <= '0;
      else if (err_evt)
        err_bit_cnt <= (bit_sum > SW'({CNT_W{1'b1}})) ? '1 : bit_sum[CNT_W-1:0];
    end
  end
`else
  assign err_bits    = '0;
  assign err_bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single/burst errors, loss and relock,
// valid gaps, counter saturation with clear, and mid-run reset.
module tb_prbs_checker;

`ifdef PRBS_CHK_BITCNT_EN
  localparam int BE = 1;
`else
  localparam int BE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, data_valid, clear_cnt;
  logic [15:0] data_in;
  logic        locked, err_word;
  logic [4:0]  err_bits;
  logic [31:0] wcnt, bcnt;
  logic        s_locked, s_err_word;
  logic [4:0]  s_err_bits;
  logic [3:0]  s_wcnt, s_bcnt;

  int          tests = 0;
  int          fails = 0;
  logic [6:0]  tb_seed;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .clear_cnt(clear_cnt), .locked(locked), .err_word(err_word),
    .err_bits(err_bits), .err_word_cnt(wcnt), .err_bit_cnt(bcnt)
  );

  prbs_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .clear_cnt(clear_cnt), .locked(s_locked), .err_word(s_err_word),
    .err_bits(s_err_bits), .err_word_cnt(s_wcnt), .err_bit_cnt(s_bcnt)
  );

  // Serial PRBS7 (x^7+x^6+1) reference; r[0] is the newest bit.
  function automatic logic [15:0] ref_word(input logic [6:0] seed);
    logic [6:0]  r;
    logic [15:0] w;
    logic        b;
    r = seed;
    w = '0;
    for (int i = 15; i >= 0; i--) begin
      b    = r[6] ^ r[5];
      w[i] = b;
      r    = {r[5:0], b};
    end
    return w;
  endfunction

  task automatic step(input logic [15:0] d, input logic v, input logic clr);
    data_in    = d;
    data_valid = v;
    clear_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] flip, input logic clr);
    logic [15:0] w;
    w       = ref_word(tb_seed);
    tb_seed = w[6:0];
    step(w ^ flip, 1'b1, clr);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(16'hFFFF, 1'b1, 1'b0);
    step(16'h1234, 1'b1, 1'b0);
    rst = 1'b0;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b want 0", locked); end
    tests++; if (err_word !== 1'b0) begin fails++; $display("FAIL reset_err_word: got %0b want 0", err_word); end
    tests++; if (err_bits !== 5'd0) begin fails++; $display("FAIL reset_err_bits: got %0d want 0", err_bits); end
    tests++; if (wcnt !== 32'd0) begin fails++; $display("FAIL reset_wcnt: got %0d want 0", wcnt); end
    tests++; if (bcnt !== 32'd0) begin fails++; $display("FAIL reset_bcnt: got %0d want 0", bcnt); end
    tests++; if (s_wcnt !== 4'd0) begin fails++; $display("FAIL reset_s_wcnt: got %0d want 0", s_wcnt); end
  endtask

  task automatic test_lock;
    int early = 0;
    int bad   = 0;
    tb_seed = 7'h7F;
    for (int k = 1; k <= 8; k++) begin
      send(16'h0, 1'b0);
      if (locked !== 1'b0) early++;
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL lock_early: %0d early-lock cycles want 0", early); end
    send(16'h0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_rise_9th: got %0b want 1", locked); end
    for (int k = 0; k < 1000; k++) begin
      send(16'h0, 1'b0);
      if (locked !== 1'b1 || err_word !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL clean_run: %0d bad cycles want 0", bad); end
    tests++; if (wcnt !== 32'd0) begin fails++; $display("FAIL clean_wcnt: got %0d want 0", wcnt); end
    tests++; if (bcnt !== 32'd0) begin fails++; $display("FAIL clean_bcnt: got %0d want 0", bcnt); end
  endtask

  task automatic test_single_err;
    send(16'h0008, 1'b0);
    tests++; if (err_word !== 1'b1) begin fails++; $display("FAIL single_err_word: got %0b want 1", err_word); end
    tests++; if (err_bits !== 5'(BE)) begin fails++; $display("FAIL single_err_bits: got %0d want %0d", err_bits, BE); end
    tests++; if (wcnt !== 32'd1) begin fails++; $display("FAIL single_wcnt: got %0d want 1", wcnt); end
    tests++; if (bcnt !== 32'(BE)) begin fails++; $display("FAIL single_bcnt: got %0d want %0d", bcnt, BE); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL single_locked: got %0b want 1", locked); end
    send(16'h0, 1'b0);
    tests++; if (err_word !== 1'b0) begin fails++; $display("FAIL no_propagate_word: got %0b want 0", err_word); end
    tests++; if (err_bits !== 5'd0) begin fails++; $display("FAIL no_propagate_bits: got %0d want 0", err_bits); end
    tests++; if (wcnt !== 32'd1) begin fails++; $display("FAIL no_propagate_wcnt: got %0d want 1", wcnt); end
  endtask

  task automatic test_loss_relock;
    int early = 0;
    step(16'h0, 1'b0, 1'b1);
    tests++; if (wcnt !== 32'd0 || bcnt !== 32'd0) begin fails++; $display("FAIL clear_cnt: got %0d/%0d want 0/0", wcnt, bcnt); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clear_locked: got %0b want 1", locked); end
    for (int k = 1; k <= 3; k++) begin
      send(16'h0003, 1'b0);
      if (locked !== 1'b1) early++;
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL loss_early: %0d early-drop cycles want 0", early); end
    send(16'h0003, 1'b0);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL loss_fall_4th: got %0b want 0", locked); end
    tests++; if (wcnt !== 32'd4) begin fails++; $display("FAIL loss_wcnt: got %0d want 4", wcnt); end
    tests++; if (bcnt !== 32'(BE * 8)) begin fails++; $display("FAIL loss_bcnt: got %0d want %0d", bcnt, BE * 8); end
    tests++; if (err_bits !== 5'(BE * 2)) begin fails++; $display("FAIL loss_err_bits: got %0d want %0d", err_bits, BE * 2); end
    early = 0;
    for (int k = 1; k <= 8; k++) begin
      send(16'h0, 1'b0);
      if (locked !== 1'b0 || err_word !== 1'b0) early++;
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL relock_early: %0d bad cycles want 0", early); end
    send(16'h0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL relock_9th: got %0b want 1", locked); end
    tests++; if (wcnt !== 32'd4) begin fails++; $display("FAIL relock_wcnt: got %0d want 4", wcnt); end
  endtask

  task automatic test_gaps;
    int  nvalid = 0;
    int  bad    = 0;
    int  cyc    = 0;
    logic v;
    rst = 1'b1;
    step(16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tb_seed = 7'h35;
    while (nvalid < 12 && cyc < 200) begin
      v = ($urandom_range(0, 1) == 1);
      if (v) begin
        send(16'h0, 1'b0);
        nvalid++;
      end else begin
        step(16'($urandom), 1'b0, 1'b0);
      end
      cyc++;
      if (locked !== (nvalid >= 9) || err_word !== 1'b0) bad++;
    end
    tests++; if (nvalid !== 12) begin fails++; $display("FAIL gaps_budget: got %0d valid words want 12", nvalid); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL gaps_lock: %0d bad cycles want 0", bad); end
    step(16'hA5A5, 1'b0, 1'b0);
    tests++; if (err_word !== 1'b0 || err_bits !== 5'd0) begin fails++; $display("FAIL invalid_quiet: got %0b/%0d want 0/0", err_word, err_bits); end
    tests++; if (wcnt !== 32'd0) begin fails++; $display("FAIL invalid_wcnt: got %0d want 0", wcnt); end
    send(16'h0, 1'b0);
    tests++; if (locked !== 1'b1 || err_word !== 1'b0) begin fails++; $display("FAIL invalid_hold: got %0b/%0b want 1/0", locked, err_word); end
  endtask

  task automatic test_saturate;
    for (int k = 0; k < 20; k++) begin
      send(16'h0100, 1'b0);
      send(16'h0, 1'b0);
    end
    tests++; if (s_wcnt !== 4'd15) begin fails++; $display("FAIL sat_wcnt: got %0d want 15", s_wcnt); end
    tests++; if (s_bcnt !== 4'(BE * 15)) begin fails++; $display("FAIL sat_bcnt: got %0d want %0d", s_bcnt, BE * 15); end
    tests++; if (wcnt !== 32'd20) begin fails++; $display("FAIL nosat_wcnt: got %0d want 20", wcnt); end
    tests++; if (bcnt !== 32'(BE * 20)) begin fails++; $display("FAIL nosat_bcnt: got %0d want %0d", bcnt, BE * 20); end
    tests++; if (s_locked !== 1'b1) begin fails++; $display("FAIL sat_locked: got %0b want 1", s_locked); end
    send(16'h0001, 1'b1);
    tests++; if (s_wcnt !== 4'd0 || wcnt !== 32'd0) begin fails++; $display("FAIL clear_wins_wcnt: got %0d/%0d want 0/0", s_wcnt, wcnt); end
    tests++; if (s_bcnt !== 4'd0 || bcnt !== 32'd0) begin fails++; $display("FAIL clear_wins_bcnt: got %0d/%0d want 0/0", s_bcnt, bcnt); end
    tests++; if (err_word !== 1'b1) begin fails++; $display("FAIL clear_err_word: got %0b want 1", err_word); end
  endtask

  task automatic test_rst_mid;
    int early = 0;
    send(16'h0004, 1'b0);
    rst = 1'b1;
    send(16'h0, 1'b0);
    rst = 1'b0;
    tests++; if (locked !== 1'b0 || err_word !== 1'b0 || err_bits !== 5'd0) begin fails++; $display("FAIL rst_mid_outs: got %0b/%0b/%0d want 0/0/0", locked, err_word, err_bits); end
    tests++; if (wcnt !== 32'd0 || bcnt !== 32'd0) begin fails++; $display("FAIL rst_mid_cnts: got %0d/%0d want 0/0", wcnt, bcnt); end
    for (int k = 1; k <= 8; k++) begin
      send(16'h0, 1'b0);
      if (locked !== 1'b0) early++;
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL rst_relock_early: %0d bad cycles want 0", early); end
    send(16'h0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL rst_relock_9th: got %0b want 1", locked); end
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    clear_cnt  = 1'b0;
    data_in    = '0;
    tb_seed    = 7'h7F;
    test_reset;
    test_lock;
    test_single_err;
    test_loss_relock;
    test_gaps;
    test_saturate;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
